debounce_scheduler: RTL and testbench

//   Debounces N_BTN push-buttons on the system clock using a single shared sample-tick divider.
//   The tick is a one-cycle enable, not a derived clock. Each tick, a round-robin scheduler

---
 rtl/debounce_scheduler.sv | 69 ++++++
 tb/tb_debounce_scheduler.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/debounce_scheduler.sv
// debounce_scheduler: round-robin debouncer for N_BTN buttons sharing one sample tick
module debounce_scheduler #(
  parameter int N_BTN      = 4,
  parameter int TICK_DIV   = 6250000,
  parameter int STABLE_CNT = 3,
  parameter int ACTIVE_LOW = 1,
  localparam int IW        = (N_BTN > 1) ? $clog2(N_BTN) : 1,
  localparam int DW        = $clog2(TICK_DIV)
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             enable,
  input  logic [N_BTN-1:0] btn_raw,
  output logic             tick,
  output logic [IW-1:0]    scan_idx,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release
);
  typedef enum logic {IDLE, SERVE} state_t;
  state_t state;
  logic [N_BTN-1:0] s1, s2, smp;
  logic [DW-1:0] div;
  logic [3:0] cnt [N_BTN];
  logic [3:0] cnt_nx;
  logic diff, flip, div_end;
  always_comb begin
    smp     = (ACTIVE_LOW != 0) ? ~s2 : s2;
    div_end = div == DW'(TICK_DIV - 1);
    diff    = smp[scan_idx] != btn_level[scan_idx];
    cnt_nx  = cnt[scan_idx] + 4'd1;
    flip    = diff && cnt_nx == 4'(STABLE_CNT);
  end
  // synchroniser keeps running while disabled; divider and tick freeze
  always_ff @(posedge clk_in or negedge rst_n)
    if (!rst_n) begin
      s1   <= '0;
      s2   <= '0;
      div  <= '0;
      tick <= 1'b0;
    end else begin
      s1   <= btn_raw;
      s2   <= s1;
      tick <= enable && div_end;
      if (enable) div <= div_end ? '0 : div + 1'b1;
    end
  always_ff @(posedge clk_in or negedge rst_n)
    if (!rst_n) begin
      state       <= IDLE;
      scan_idx    <= '0;
      btn_level   <= '0;
      btn_press   <= '0;
      btn_release <= '0;
      for (int i = 0; i < N_BTN; i++) cnt[i] <= '0;
    end else begin
      btn_press   <= '0;
      btn_release <= '0;
      state       <= (state == IDLE && tick) ? SERVE : IDLE;
      if (state == SERVE) begin
        cnt[scan_idx] <= (diff && !flip) ? cnt_nx : 4'd0;
        scan_idx      <= (scan_idx == IW'(N_BTN - 1)) ? '0 : scan_idx + 1'b1;
        if (flip) begin
          btn_level[scan_idx]   <= smp[scan_idx];
          btn_press[scan_idx]   <= smp[scan_idx];
          btn_release[scan_idx] <= ~smp[scan_idx];
        end
      end
    end
endmodule

// File: tb/tb_debounce_scheduler.sv
// tb_debounce_scheduler: directed table and sequence checks for debounce_scheduler (N_BTN=2, TICK_DIV=4)
module tb_debounce_scheduler;
  logic clk_in = 1'b0;
  logic rst_n = 1'b1;
  logic enable = 1'b1;
  logic [1:0] btn_raw = '0;
  logic tick;
  logic [0:0] scan_idx;
  logic [1:0] btn_level, btn_press, btn_release;
  int n_chk = 0, n_fail = 0, e = 0;
  int press_n [2];
  int rel_n [2];

  debounce_scheduler #(.N_BTN(2), .TICK_DIV(4), .STABLE_CNT(3), .ACTIVE_LOW(0)) dut (
    .clk_in(clk_in), .rst_n(rst_n), .enable(enable), .btn_raw(btn_raw), .tick(tick),
    .scan_idx(scan_idx), .btn_level(btn_level), .btn_press(btn_press), .btn_release(btn_release)
  );

  always #5 clk_in = ~clk_in;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  typedef struct {
    int e;
    logic tick;
    logic [0:0] idx;
    logic [1:0] lvl;
    logic [1:0] prs;
    logic [1:0] rel;
  } vec_t;
  vec_t tv [11];

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", name, e, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
    e++;
    chk("single_pulse", ($countones({btn_press, btn_release}) > 1) ? 1 : 0, 0);
    for (int i = 0; i < 2; i++) begin
      press_n[i] += int'(btn_press[i]);
      rel_n[i] += int'(btn_release[i]);
    end
  endtask

  task automatic do_reset(input logic [1:0] raw);
    @(negedge clk_in);
    rst_n = 1'b0;
    btn_raw = raw;
    enable = 1'b1;
    #1;
    chk("rst_async_out", int'({tick, btn_level, btn_press, btn_release}), 0);
    @(posedge clk_in);
    #1;
    chk("rst_held_out", int'({tick, scan_idx, btn_level, btn_press, btn_release}), 0);
    @(negedge clk_in);
    rst_n = 1'b1;
    e = 0;
    press_n = '{0, 0};
    rel_n = '{0, 0};
  endtask

  initial begin
    int ticks, changes;
    logic [0:0] prev;
    tv[0]  = '{3,  1'b0, 1'b0, 2'b00, 2'b00, 2'b00};
    tv[1]  = '{4,  1'b1, 1'b0, 2'b00, 2'b00, 2'b00};
    tv[2]  = '{5,  1'b0, 1'b0, 2'b00, 2'b00, 2'b00};
    tv[3]  = '{6,  1'b0, 1'b1, 2'b00, 2'b00, 2'b00};
    tv[4]  = '{8,  1'b1, 1'b1, 2'b00, 2'b00, 2'b00};
    tv[5]  = '{10, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00};
    tv[6]  = '{14, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00};
    tv[7]  = '{21, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00};
    tv[8]  = '{22, 1'b0, 1'b1, 2'b01, 2'b01, 2'b00};
    tv[9]  = '{23, 1'b0, 1'b1, 2'b01, 2'b00, 2'b00};
    tv[10] = '{24, 1'b1, 1'b1, 2'b01, 2'b00, 2'b00};

    // idle run: regular ticks, alternating scan, nothing pressed
    do_reset(2'b00);
    ticks = 0;
    changes = 0;
    prev = scan_idx;
    for (int c = 0; c < 100; c++) begin
      step();
      if (tick) begin
        ticks++;
        chk("t1_tick_phase", e % 4, 0);
      end
      if (scan_idx != prev) changes++;
      prev = scan_idx;
      if (btn_level != 0 || btn_press != 0 || btn_release != 0)
        chk("t1_quiet", int'({btn_level, btn_press, btn_release}), 0);
    end
    chk("t1_tick_count", ticks, 25);
    chk("t1_scan_changes", changes, 24);
    chk("t1_press_total", press_n[0] + press_n[1], 0);

    // btn0 held from reset: table of expected per-cycle outputs
    do_reset(2'b01);
    for (int i = 0; i < 11; i++) begin
      while (e < tv[i].e && e < 200) step();
      chk("t2_tick", int'(tick), int'(tv[i].tick));
      chk("t2_idx", int'(scan_idx), int'(tv[i].idx));
      chk("t2_level", int'(btn_level), int'(tv[i].lvl));
      chk("t2_press", int'(btn_press), int'(tv[i].prs));
      chk("t2_release", int'(btn_release), int'(tv[i].rel));
    end
    while (e < 40) step();
    chk("t2_press_n", press_n[0], 1);
    chk("t2_rel_n", rel_n[0] + rel_n[1], 0);

    // bounce on the tick-3 sample of btn0 restarts its count
    do_reset(2'b01);
    while (e < 45) begin
      step();
      if (e == 11) btn_raw = 2'b00;
      if (e == 12) btn_raw = 2'b01;
      if (e == 22) chk("t3_level_e22", int'(btn_level), 0);
      if (e == 30) chk("t3_level_e30", int'(btn_level), 0);
      if (e == 37) chk("t3_level_e37", int'(btn_level), 0);
      if (e == 38) chk("t3_press_e38", int'(btn_press), 1);
      if (e == 38) chk("t3_level_e38", int'(btn_level), 1);
    end
    chk("t3_press_n", press_n[0], 1);

    // both held, then both released
    do_reset(2'b11);
    while (e < 60) begin
      step();
      if (e == 30) btn_raw = 2'b00;
      if (e == 22) chk("t4_press0", int'(btn_press), 1);
      if (e == 26) chk("t4_press1", int'(btn_press), 2);
      if (e == 30) chk("t4_level_both", int'(btn_level), 3);
      if (e == 50) chk("t4_release1", int'(btn_release), 2);
      if (e == 54) chk("t4_release0", int'(btn_release), 1);
    end
    chk("t4_press_n0", press_n[0], 1);
    chk("t4_press_n1", press_n[1], 1);
    chk("t4_rel_n0", rel_n[0], 1);
    chk("t4_rel_n1", rel_n[1], 1);
    chk("t4_level_end", int'(btn_level), 0);

    // enable low for 20 cycles with cnt[0]=2
    do_reset(2'b01);
    while (e < 45) begin
      step();
      if (e == 14) enable = 1'b0;
      if (e == 34) enable = 1'b1;
      if (e >= 15 && e <= 34) begin
        if (tick != 1'b0) chk("t5_tick_frozen", int'(tick), 0);
        if (scan_idx != 1'b1) chk("t5_idx_frozen", int'(scan_idx), 1);
      end
      if (e == 34) chk("t5_idx_e34", int'(scan_idx), 1);
      if (e == 36) chk("t5_tick_resume", int'(tick), 1);
      if (e == 41) chk("t5_level_e41", int'(btn_level), 0);
      if (e == 42) chk("t5_press_e42", int'(btn_press), 1);
      if (e == 42) chk("t5_level_e42", int'(btn_level), 1);
    end

    // reset while btn1 is down: no release pulse, level re-acquired
    do_reset(2'b10);
    while (e < 30) step();
    chk("t6_level_pre", int'(btn_level), 2);
    do_reset(2'b10);
    chk("t6_rel_after_rst", int'(btn_release), 0);
    while (e < 30) begin
      step();
      if (e == 25) chk("t6_level_e25", int'(btn_level), 0);
      if (e == 26) chk("t6_press_e26", int'(btn_press), 2);
      if (e == 26) chk("t6_level_e26", int'(btn_level), 2);
    end
    chk("t6_rel_n", rel_n[0] + rel_n[1], 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
